// File: rtl/hit_judge_if.sv
// hit_judge_if: round-control, switch and result signals shared by the reaction-game judge and its driver
//  master: drives start, target, switch, clear_score; observes the results
//  slave : the judge; drives led_out, busy, hit, miss, miss_cause, bad_target, score, streak
interface hit_judge_if #(
  parameter int N_SW    = 8,
  parameter int SCORE_W = 8
);
  logic               start;
  logic [N_SW-1:0]    target;
  logic [N_SW-1:0]    switch;
  logic               clear_score;
  logic [N_SW-1:0]    led_out;
  logic               busy;
  logic               hit;
  logic               miss;
  logic [1:0]         miss_cause;
  logic               bad_target;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] streak;
  modport master (
    output start, target, switch, clear_score,
    input  led_out, busy, hit, miss, miss_cause, bad_target, score, streak
  );
  modport slave (
    input  start, target, switch, clear_score,
    output led_out, busy, hit, miss, miss_cause, bad_target, score, streak
  );
endinterface

// File: rtl/hit_judge.sv
// hit_judge: reaction-game judge; lights a one-hot lane for WINDOW cycles and scores the first switch toggle
//  clk, rst_n : rising-edge clock, asynchronous active-low reset
//  bus.start/target/switch/clear_score : round request, lane to light, synchronised switches, score clear
//  bus.led_out/busy : lit lane and round-in-progress flag
//  bus.hit/miss/miss_cause/bad_target : one-cycle result pulses (cause 01 wrong, 10 timeout, 11 early)
//  bus.score/streak : saturating hit count and consecutive-hit count
module hit_judge #(
  parameter int N_SW       = 8,
  parameter int WINDOW     = 100_000_000,
  parameter int TW         = 32,
  parameter int SCORE_W    = 8,
  parameter bit EARLY_MISS = 1'b1
) (
  input logic        clk,
  input logic        rst_n,
  hit_judge_if.slave bus
);
  typedef enum logic {IDLE, ARMED} state_t;
  state_t             state, state_nx;
  logic [N_SW-1:0]    tgt, tgt_nx, sw_prev, tog;
  logic [TW-1:0]      timer, timer_nx;
  logic               primed;
  logic               hit_nx, miss_nx, bad_nx;
  logic [1:0]         cause_nx;
  logic [SCORE_W-1:0] score_nx, streak_nx;
  assign tog = bus.switch ^ sw_prev;
  // The first edge after reset only captures the switch levels, so levels held through reset never count as toggles.
  always_comb begin
    state_nx  = state;
    tgt_nx    = tgt;
    timer_nx  = timer;
    hit_nx    = 1'b0;
    miss_nx   = 1'b0;
    bad_nx    = 1'b0;
    cause_nx  = 2'b00;
    if (primed && state == IDLE) begin
      if (bus.start) begin
        if ($onehot(bus.target)) begin
          tgt_nx   = bus.target;
          timer_nx = TW'(WINDOW);
          state_nx = ARMED;
        end else
          bad_nx = 1'b1;
      end else if (|tog && EARLY_MISS) begin
        miss_nx  = 1'b1;
        cause_nx = 2'b11;
      end
    end else if (primed) begin
      // A toggle on the final window edge still counts: it is checked before the timeout.
      if (|tog) begin
        hit_nx   = tog == tgt;
        miss_nx  = tog != tgt;
        cause_nx = tog == tgt ? 2'b00 : 2'b01;
        state_nx = IDLE;
      end else begin
        timer_nx = timer - 1'b1;
        miss_nx  = timer == TW'(1);
        cause_nx = timer == TW'(1) ? 2'b10 : 2'b00;
        state_nx = timer == TW'(1) ? IDLE : ARMED;
      end
    end
    score_nx  = bus.clear_score ? '0 : hit_nx && !(&bus.score) ? bus.score + 1'b1 : bus.score;
    streak_nx = bus.clear_score || miss_nx ? '0 : hit_nx && !(&bus.streak) ? bus.streak + 1'b1 : bus.streak;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state          <= IDLE;
      tgt            <= '0;
      timer          <= '0;
      sw_prev        <= '0;
      primed         <= 1'b0;
      bus.led_out    <= '0;
      bus.busy       <= 1'b0;
      bus.hit        <= 1'b0;
      bus.miss       <= 1'b0;
      bus.miss_cause <= 2'b00;
      bus.bad_target <= 1'b0;
      bus.score      <= '0;
      bus.streak     <= '0;
    end else begin
      state          <= state_nx;
      tgt            <= tgt_nx;
      timer          <= timer_nx;
      sw_prev        <= bus.switch;
      primed         <= 1'b1;
      bus.led_out    <= state_nx == ARMED ? tgt_nx : '0;
      bus.busy       <= state_nx == ARMED;
      bus.hit        <= hit_nx;
      bus.miss       <= miss_nx;
      bus.miss_cause <= cause_nx;
      bus.bad_target <= bad_nx;
      bus.score      <= score_nx;
      bus.streak     <= streak_nx;
    end
endmodule
